// File: rtl/axe_clk_cycle_timer.sv
// Multi-channel cycle timer: each channel pulses expire N edges after being armed (one-shot or periodic).
// Plus a free-running, silently wrapping edge counter. All outputs are registered.
module axe_clk_cycle_timer #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned CYC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH*CNT_W-1:0] load_val,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH-1:0]       abort,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       expire,
  output logic [NUM_CH-1:0]       err,
  output logic [NUM_CH*CNT_W-1:0] remaining,
  output logic [CYC_W-1:0]        cycle_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic               mode_q, mode_d;
    logic               exp_q, exp_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   n;

    assign n = load_val[i*CNT_W +: CNT_W];

    // Priority: abort > valid start > (zero-length start flags err but lets a live run continue).
    always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      period_d = period_q;
      mode_d   = mode_q;
      exp_d    = 1'b0;
      err_d    = 1'b0;

      if (abort[i]) begin
        state_d = IDLE;
        rem_d   = '0;
      end else if (start[i] && (n != '0)) begin
        state_d  = RUN;
        rem_d    = n;
        period_d = n;
        mode_d   = periodic[i];
      end else begin
        if (start[i]) begin
          err_d = 1'b1;
        end
        if (state_q == RUN) begin
          if (rem_q == CNT_W'(1)) begin
            exp_d = 1'b1;
            if (mode_q) begin
              rem_d = period_q;
            end else begin
              rem_d   = '0;
              state_d = IDLE;
            end
          end else begin
            rem_d = rem_q - CNT_W'(1);
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q  <= IDLE;
        rem_q    <= '0;
        period_q <= '0;
        mode_q   <= 1'b0;
        exp_q    <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        state_q  <= state_d;
        rem_q    <= rem_d;
        period_q <= period_d;
        mode_q   <= mode_d;
        exp_q    <= exp_d;
        err_q    <= err_d;
      end
    end

    assign busy[i]                     = (state_q == RUN);
    assign expire[i]                   = exp_q;
    assign err[i]                      = err_q;
    assign remaining[i*CNT_W +: CNT_W] = rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CYC_W'(1);
    end
  end

endmodule
